// File: rtl/tb_spi_mem_model_if.sv
// Pin bundle between the tinyrv bench and the SPI memory responder: SPI wires plus the backdoor port.
interface tb_spi_mem_model_if #(
   parameter int DEPTH_LOG2 = 12
);
   logic                  cs_n;
   logic                  sck;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic                  bd_we;
   logic [DEPTH_LOG2-1:0] bd_addr;
   logic [7:0]            bd_wdata;
   logic [7:0]            bd_rdata;

   modport master (
      output cs_n, sck, mosi, bd_we, bd_addr, bd_wdata,
      input  miso, miso_oe, bd_rdata
   );

   modport slave (
      input  cs_n, sck, mosi, bd_we, bd_addr, bd_wdata,
      output miso, miso_oe, bd_rdata
   );
endinterface

// File: rtl/tb_spi_mem_model.sv
// Clock-oversampled SPI memory responder (READ 0x03, WRITE 0x02, READ-STATUS 0x05) with a backdoor port.
// Define TB_SPI_MEM_FAST_READ_EN to accept FAST-READ 0x0B (8 dummy clocks before data).
//
// state  | meaning
// IDLE   | cs_n high, waiting for cs_n falling
// CMD    | shifting in the 8-bit command
// ADDR   | shifting in 8*ADDR_BYTES address bits
// DUMMY  | fast-read dummy clocks, driving 0 (fast-read build only)
// READ   | shifting memory bytes out, auto-increment
// WRITE  | assembling bytes and committing them, auto-increment
// STAT   | repeating STATUS_VAL
// IGNORE | unknown command, silent until cs_n rises
module tb_spi_mem_model #(
   parameter int         ADDR_BYTES = 3,
   parameter int         DEPTH_LOG2 = 12,
   parameter logic [7:0] STATUS_VAL = 8'h00
) (
   input  logic                clk,
   input  logic                rst,
   tb_spi_mem_model_if.slave   bus,
   output logic [15:0]         cmd_count,
   output logic                err
);

   localparam int          ADDR_BITS = 8 * ADDR_BYTES;
   localparam int          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << ADDR_BITS) - 32'd1);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, READ, WRITE, STAT, IGNORE
`ifdef TB_SPI_MEM_FAST_READ_EN
      , DUMMY
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [1:0]            cs_sync, sck_sync, mosi_sync;
   logic                  cs_prev, sck_prev;
   logic                  cs_s, mosi_s, sck_rise, sck_fall, cs_fall;
   logic [5:0]            bit_cnt, bit_cnt_nxt;
   logic [30:0]           shift_in;
   logic [7:0]            cmd, cmd_nxt;
   logic [DEPTH_LOG2-1:0] addr, addr_nxt, addr_rx;
   logic                  data_done, data_done_nxt;
   logic                  miso_q, miso_nxt;
   logic [7:0]            rx_byte, rd_byte, bd_rdata_q;
   logic                  spi_we, count_inc, err_set;
   logic                  pend_vld;
   logic [DEPTH_LOG2-1:0] pend_addr;
   logic [7:0]            pend_data;
   logic [7:0]            mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= 2'b11;
         sck_sync  <= 2'b00;
         mosi_sync <= 2'b00;
         cs_prev   <= 1'b1;
         sck_prev  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], bus.cs_n};
         sck_sync  <= {sck_sync[0], bus.sck};
         mosi_sync <= {mosi_sync[0], bus.mosi};
         cs_prev   <= cs_sync[1];
         sck_prev  <= sck_sync[1];
      end
   end

   assign cs_s     = cs_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign sck_rise = sck_sync[1] & ~sck_prev;
   assign sck_fall = ~sck_sync[1] & sck_prev;
   assign cs_fall  = cs_prev & ~cs_s;

   assign rx_byte = {shift_in[6:0], mosi_s};
   assign addr_rx = DEPTH_LOG2'({shift_in, mosi_s} & ADDR_MASK);
   assign rd_byte = mem[addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cmd       <= '0;
         addr      <= '0;
         data_done <= 1'b0;
         miso_q    <= 1'b0;
         shift_in  <= '0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         cmd       <= cmd_nxt;
         addr      <= addr_nxt;
         data_done <= data_done_nxt;
         miso_q    <= miso_nxt;
         if (sck_rise) shift_in <= {shift_in[29:0], mosi_s};
      end
   end

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      cmd_nxt       = cmd;
      addr_nxt      = addr;
      data_done_nxt = data_done;
      miso_nxt      = miso_q;
      spi_we        = 1'b0;
      count_inc     = 1'b0;
      err_set       = 1'b0;
      if (state != IDLE && cs_s) begin
         state_nxt   = IDLE;
         bit_cnt_nxt = '0;
         miso_nxt    = 1'b0;
         if (state == CMD || state == ADDR) err_set = 1'b1;
         if (data_done || state == STAT) count_inc = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               miso_nxt = 1'b0;
               if (cs_fall) begin
                  state_nxt     = CMD;
                  bit_cnt_nxt   = '0;
                  data_done_nxt = 1'b0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  if (bit_cnt == 6'd7) begin
                     bit_cnt_nxt = '0;
                     cmd_nxt     = rx_byte;
                     case (rx_byte)
                        8'h02, 8'h03: state_nxt = ADDR;
`ifdef TB_SPI_MEM_FAST_READ_EN
                        8'h0B:        state_nxt = ADDR;
`endif
                        8'h05:        state_nxt = STAT;
                        default: begin
                           state_nxt = IGNORE;
                           err_set   = 1'b1;
                        end
                     endcase
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  if (bit_cnt == 6'(ADDR_BITS - 1)) begin
                     bit_cnt_nxt = '0;
                     addr_nxt    = addr_rx;
                     if (cmd == 8'h02) state_nxt = WRITE;
`ifdef TB_SPI_MEM_FAST_READ_EN
                     else if (cmd == 8'h0B) state_nxt = DUMMY;
`endif
                     else state_nxt = READ;
                  end
               end
            end
`ifdef TB_SPI_MEM_FAST_READ_EN
            DUMMY: begin
               if (sck_fall) miso_nxt = 1'b0;
               if (sck_rise) begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  if (bit_cnt == 6'd7) begin
                     bit_cnt_nxt = '0;
                     state_nxt   = READ;
                  end
               end
            end
`endif
            READ: begin
               // bit_cnt counts bits already driven; a rise with none pending closes a byte
               if (sck_rise && bit_cnt == 6'd0) data_done_nxt = 1'b1;
               if (sck_fall) begin
                  miso_nxt    = rd_byte[3'd7 - bit_cnt[2:0]];
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  if (bit_cnt == 6'd7) begin
                     bit_cnt_nxt = '0;
                     addr_nxt    = addr + 1'b1;
                  end
               end
            end
            STAT: begin
               if (sck_fall) begin
                  miso_nxt    = STATUS_VAL[3'd7 - bit_cnt[2:0]];
                  bit_cnt_nxt = (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
               end
            end
            WRITE: begin
               if (sck_rise) begin
                  bit_cnt_nxt = bit_cnt + 6'd1;
                  if (bit_cnt == 6'd7) begin
                     bit_cnt_nxt   = '0;
                     spi_we        = 1'b1;
                     addr_nxt      = addr + 1'b1;
                     data_done_nxt = 1'b1;
                  end
               end
            end
            IGNORE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef TB_SPI_MEM_FAST_READ_EN
   assign bus.miso_oe = ~cs_s & (state == READ || state == STAT || state == DUMMY);
`else
   assign bus.miso_oe = ~cs_s & (state == READ || state == STAT);
`endif
   assign bus.miso     = miso_q;
   assign bus.bd_rdata = bd_rdata_q;

   // Backdoor owns the single write port; a clashing SPI byte waits one cycle in pend_*
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld  <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
      end else if (spi_we && (bus.bd_we || pend_vld)) begin
         pend_vld  <= 1'b1;
         pend_addr <= addr;
         pend_data <= rx_byte;
      end else if (!bus.bd_we) begin
         pend_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.bd_we)              mem[bus.bd_addr] <= bus.bd_wdata;
      else if (!rst && pend_vld)  mem[pend_addr]   <= pend_data;
      else if (!rst && spi_we)    mem[addr]        <= rx_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) bd_rdata_q <= '0;
      else     bd_rdata_q <= mem[bus.bd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_count <= '0;
         err       <= 1'b0;
      end else begin
         if (count_inc && cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
         if (err_set) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tb_spi_mem_model.sv
// Directed bench for the SPI memory responder: read, write with wrap, status, errors, backdoor collision.
module tb_tb_spi_mem_model;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd_count;
   logic        err;
   logic [7:0]  rx;
   logic [7:0]  bd;
   int          n_tests = 0;
   int          n_fail  = 0;

   tb_spi_mem_model_if #(.DEPTH_LOG2(12)) bus ();

   tb_spi_mem_model #(
      .ADDR_BYTES (3),
      .DEPTH_LOG2 (12),
      .STATUS_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cmd_count (cmd_count),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // sck = clk/8, mode 0; miso is sampled just before each rising edge
   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rdat);
      rdat = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.mosi = tx[i];
         clk_wait(4);
         rdat[i]  = bus.miso;
         bus.sck  = 1'b1;
         clk_wait(4);
         bus.sck  = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rdat);
      spi_xfer(tx, 8, rdat);
   endtask

   task automatic spi_start();
      bus.cs_n = 1'b0;
      clk_wait(4);
   endtask

   task automatic spi_end();
      clk_wait(4);
      bus.cs_n = 1'b1;
      clk_wait(6);
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
      bus.bd_addr  = a;
      bus.bd_wdata = d;
      bus.bd_we    = 1'b1;
      clk_wait(1);
      bus.bd_we    = 1'b0;
   endtask

   task automatic bd_read(input logic [11:0] a, output logic [7:0] d);
      bus.bd_addr = a;
      clk_wait(2);
      d = bus.bd_rdata;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clk_wait(3);
      rst = 1'b0;
      clk_wait(2);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bus.cs_n     = 1'b1;
      bus.sck      = 1'b0;
      bus.mosi     = 1'b0;
      bus.bd_we    = 1'b0;
      bus.bd_addr  = '0;
      bus.bd_wdata = '0;
      rst          = 1'b1;
      clk_wait(4);
      chk_eq("rst_miso",      32'(bus.miso),     32'h0);
      chk_eq("rst_miso_oe",   32'(bus.miso_oe),  32'h0);
      chk_eq("rst_bd_rdata",  32'(bus.bd_rdata), 32'h0);
      chk_eq("rst_cmd_count", 32'(cmd_count),    32'h0);
      chk_eq("rst_err",       32'(err),          32'h0);
      rst = 1'b0;
      clk_wait(2);

      // READ across two bytes
      bd_write(12'h010, 8'hA5);
      bd_write(12'h011, 8'h3C);
      bd_read(12'h010, bd);
      chk_eq("bd_preload", 32'(bd), 32'hA5);
      spi_start();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      spi_byte(8'h00, rx);
      chk_eq("read_b0", 32'(rx), 32'hA5);
      chk_eq("read_oe", 32'(bus.miso_oe), 32'h1);
      spi_byte(8'h00, rx);
      chk_eq("read_b1", 32'(rx), 32'h3C);
      spi_end();
      chk_eq("read_count",  32'(cmd_count),   32'h1);
      chk_eq("read_err",    32'(err),         32'h0);
      chk_eq("read_oe_off", 32'(bus.miso_oe), 32'h0);

      // WRITE wrapping from the top of memory to 0
      spi_start();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h0F, rx);
      spi_byte(8'hFF, rx);
      spi_byte(8'hDE, rx);
      spi_byte(8'hAD, rx);
      spi_end();
      bd_read(12'hFFF, bd);
      chk_eq("wr_fff", 32'(bd), 32'hDE);
      bd_read(12'h000, bd);
      chk_eq("wr_wrap_000", 32'(bd), 32'hAD);
      chk_eq("wr_count", 32'(cmd_count), 32'h2);

      // READ-STATUS
      spi_start();
      spi_xfer(8'h05, 7, rx);
      chk_eq("stat_oe_cmd", 32'(bus.miso_oe), 32'h0);
      spi_xfer(8'h80, 1, rx);
      chk_eq("stat_oe_on", 32'(bus.miso_oe), 32'h1);
      spi_byte(8'h00, rx);
      chk_eq("stat_b0", 32'(rx), 32'h00);
      spi_byte(8'h00, rx);
      chk_eq("stat_b1", 32'(rx), 32'h00);
      spi_end();
      chk_eq("stat_oe_off", 32'(bus.miso_oe), 32'h0);
      chk_eq("stat_count",  32'(cmd_count),   32'h3);
      chk_eq("stat_err",    32'(err),         32'h0);

      // unknown command
      spi_start();
      spi_byte(8'h9F, rx);
      chk_eq("unk_err", 32'(err),         32'h1);
      chk_eq("unk_oe",  32'(bus.miso_oe), 32'h0);
      spi_byte(8'h00, rx);
      chk_eq("unk_oe_data", 32'(bus.miso_oe), 32'h0);
      spi_end();
      chk_eq("unk_count", 32'(cmd_count), 32'h3);

      do_reset();
      chk_eq("rst2_err",   32'(err),       32'h0);
      chk_eq("rst2_count", 32'(cmd_count), 32'h0);
      bd_read(12'h010, bd);
      chk_eq("rst2_mem_kept", 32'(bd), 32'hA5);

      // write aborted after 12 address bits, then a clean read
      spi_start();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_xfer(8'h00, 4, rx);
      spi_end();
      chk_eq("abort_err",   32'(err),       32'h1);
      chk_eq("abort_count", 32'(cmd_count), 32'h0);
      bd_read(12'h010, bd);
      chk_eq("abort_mem", 32'(bd), 32'hA5);
      spi_start();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      spi_byte(8'h00, rx);
      chk_eq("abort_next_read", 32'(rx), 32'hA5);
      spi_end();
      chk_eq("abort_next_count", 32'(cmd_count), 32'h1);

      // backdoor write lands in the same cycle as the SPI byte commit
      spi_start();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h21, rx);
      spi_xfer(8'h77, 7, rx);
      bus.mosi = 1'b1;
      clk_wait(4);
      bus.sck = 1'b1;
      clk_wait(2);
      bus.bd_addr  = 12'h020;
      bus.bd_wdata = 8'h55;
      bus.bd_we    = 1'b1;
      clk_wait(1);
      bus.bd_we    = 1'b0;
      clk_wait(1);
      bus.sck = 1'b0;
      spi_end();
      bd_read(12'h020, bd);
      chk_eq("coll_bd_020", 32'(bd), 32'h55);
      bd_read(12'h021, bd);
      chk_eq("coll_spi_021", 32'(bd), 32'h77);
      chk_eq("coll_count", 32'(cmd_count), 32'h2);

      // FAST-READ
      do_reset();
      spi_start();
      spi_byte(8'h0B, rx);
`ifdef TB_SPI_MEM_FAST_READ_EN
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      chk_eq("fast_dummy_oe", 32'(bus.miso_oe), 32'h1);
      spi_byte(8'h00, rx);
      chk_eq("fast_dummy_data", 32'(rx), 32'h00);
      spi_byte(8'h00, rx);
      chk_eq("fast_read_b0", 32'(rx), 32'hA5);
      spi_end();
      chk_eq("fast_err",   32'(err),       32'h0);
      chk_eq("fast_count", 32'(cmd_count), 32'h1);
`else
      chk_eq("fast_off_err", 32'(err),         32'h1);
      chk_eq("fast_off_oe",  32'(bus.miso_oe), 32'h0);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      chk_eq("fast_off_oe_data", 32'(bus.miso_oe), 32'h0);
      spi_end();
      chk_eq("fast_off_count", 32'(cmd_count), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
